// File: rtl/pipe_skid_fifo.sv
// Circular-buffer FIFO with a registered upstream ready, optional zero-latency
// pass-through when empty, and synchronous flush.
module pipe_skid_fifo #(
    parameter int L      = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         valid_f,
    output logic                         ready_f,
    input  logic [L-1:0]                 data_f,
    output logic                         valid_b,
    input  logic                         ready_b,
    output logic [L-1:0]                 data_b,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [L-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_f_q, ready_f_d;

    logic stored;
    logic push;
    logic pop;
    logic write;
    logic read;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        stored  = (count_q != '0);
        push    = valid_f & ready_f_q & ~flush;
        valid_b = 1'b0;
        data_b  = data_f;

        if (stored) begin
            valid_b = ~flush;
            data_b  = mem_q[rd_ptr_q];
        end else if (BYPASS != 0) begin
            valid_b = push;
        end

        pop   = valid_b & ready_b;
        // An empty-buffer pop can only be the bypassed beat itself, so it skips storage.
        write = push & ~(~stored & pop);
        read  = pop & stored;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (write) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (read)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (write && !read)      count_d = count_q + CW'(1);
        else if (read && !write) count_d = count_q - CW'(1);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ready_f_d = (count_d < CW'(DEPTH)) & ~flush;
    end

    // NOTE: state flops use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_f_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_f_q <= ready_f_d;
        end
    end

    // NOTE: storage is reset to zero here; flush leaves contents alone and only moves pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (write) begin
            mem_q[wr_ptr_q] <= data_f;
        end
    end

    assign ready_f = ready_f_q;
    assign count   = count_q;

endmodule

// File: doc/pipe_skid_fifo.md
PIPE_SKID_FIFO -- requirements
Module: pipe_skid_fifo

Interface
REQ-001 Parameter: L, default 8, payload width in bits (>=1).
REQ-002 Parameter: DEPTH, default 4, storage entries (power of two, >=2).
REQ-003 Parameter: BYPASS, default 1; 1 = empty-buffer combinational pass-through, 0 = always via storage.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-low.
REQ-006 Port: flush  input  1  synchronous clear of all buffered beats.
REQ-007 Port: valid_f  input  1  upstream beat valid.
REQ-008 Port: ready_f  output  1  upstream ready, driven directly from a flop.
REQ-009 Port: data_f  input  L  upstream payload.
REQ-010 Port: valid_b  output  1  downstream beat valid.
REQ-011 Port: ready_b  input  1  downstream ready.
REQ-012 Port: data_b  output  L  downstream payload.
REQ-013 Port: count  output  clog2(DEPTH+1)  entries held, registered.

Function
REQ-014 Upstream handshake (push) SHALL occur when valid_f and ready_f are both 1 on a rising edge; downstream handshake (pop) when valid_b and ready_b are both 1.
REQ-015 ready_f SHALL be a flop whose next value is (count_next < DEPTH) and not flush; no combinational path from ready_b to ready_f.
REQ-016 Storage SHALL be a circular buffer: write pointer, read pointer, count; pointers wrap from DEPTH-1 to 0.
REQ-017 count > 0: valid_b = 1, data_b = entry at read pointer; pop advances read pointer.
REQ-018 count = 0, BYPASS=1: valid_b = valid_f and ready_f, data_b = data_f combinationally (0-cycle latency).
REQ-019 count = 0, BYPASS=1, push with ready_b=1: beat passes through; no write, count stays 0.
REQ-020 count = 0, BYPASS=1, push with ready_b=0: beat written to storage, count becomes 1.
REQ-021 count = 0, BYPASS=0: valid_b = 0; push writes storage; earliest valid_b is next cycle (1-cycle latency).
REQ-022 Push and pop in same cycle with count > 0: write and read both occur, count unchanged.
REQ-023 Push only: count+1; pop only: count-1; count SHALL never exceed DEPTH nor go below 0.
REQ-024 Full (count = DEPTH): ready_f = 0 from the following edge; a pop in the full cycle re-asserts ready_f on the next edge.
REQ-025 Order SHALL be strictly FIFO; no beat duplicated or lost except under flush.
REQ-026 flush=1: valid_b forced 0 that cycle; any push that cycle discarded; pointers and count cleared at the edge; ready_f = 0 for that one following cycle, then per REQ-015.
REQ-027 data_b SHALL be don't-care when valid_b = 0; storage contents not cleared by flush.

Reset
REQ-028 rst low SHALL asynchronously set count=0, pointers=0, ready_f=1, valid_b=0 (BYPASS=1: valid_b then follows valid_f), storage data to 0.
REQ-029 rst low mid-operation SHALL discard all held beats; first push after release is the first beat delivered.

Verification
REQ-030 L=8, DEPTH=4, BYPASS=1, ready_b=1, push 0x11,0x22,0x33 back-to-back -> data_b = same values, same cycles, count stays 0.
REQ-031 ready_b=0, push 0xA0..0xA4 -> first four accepted, count=4, ready_f=0 from edge after fourth push, 0xA4 held upstream; ready_b=1 -> outputs 0xA0,0xA1,0xA2,0xA3,0xA4 in order.
REQ-032 count=2, simultaneous push and pop for 10 cycles -> count stays 2, order preserved, pointers wrap without error.
REQ-033 BYPASS=0, empty, push 0x5A with ready_b=1 -> valid_b=1, data_b=0x5A exactly one cycle later.
REQ-034 count=3, flush pulse with valid_f=1 data_f=0x77 -> count=0 next edge, 0x77 never appears, ready_f low one cycle.
REQ-035 rst asserted with count=3 -> count=0, ready_f=1 immediately, held data never appears on data_b.
